// File: rtl/or_chk_pkg.sv
// Shared types and helpers for the OR-gate stimulus/response checker.
package or_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned VEC_W   = 2;

    // Golden response of the gate under test.
    function automatic logic exp_or(input logic a, input logic b);
        return a | b;
    endfunction

endpackage

// File: rtl/or_hold_timer.sv
// Settle-time counter: expire is high on the last cycle a vector is held in APPLY.
module or_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = (cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/or_resp_checker.sv
// Drives all four input vectors into a 2-input OR gate, samples z after a settle
// time and accumulates pass / saturating error count / per-vector failure map.
module or_resp_checker
    import or_chk_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned ERR_W       = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               x,
    output logic               y,
    input  logic               z,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [NUM_VEC-1:0] fail_vec
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             state, state_d;
    logic [VEC_W-1:0]   vec, vec_d, vec_nxt;
    logic               x_d, y_d, busy_d, done_d, pass_d;
    logic [ERR_W-1:0]   err_d;
    logic [NUM_VEC-1:0] fail_d;
    logic               expire;
    logic               timer_clear;
    logic               mismatch;

    assign timer_clear = (state != APPLY);

    or_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .expire (expire)
    );

    assign mismatch = (z != exp_or(x, y));
    assign vec_nxt  = vec + VEC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state;
        vec_d   = vec;
        x_d     = x;
        y_d     = y;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_cnt;
        fail_d  = fail_vec;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    vec_d   = '0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            APPLY: begin
                x_d = vec[1];
                y_d = vec[0];
                if (expire) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_d = fail_vec | (NUM_VEC'(1) << vec);
                    err_d  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);
                end
                // Pass must reflect the result of this final compare as well.
                if (vec == VEC_W'(NUM_VEC - 1)) begin
                    state_d = FINISH;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_nxt;
                    x_d     = vec_nxt[1];
                    y_d     = vec_nxt[0];
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec      <= '0;
            x        <= 1'b0;
            y        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            vec      <= vec_d;
            x        <= x_d;
            y        <= y_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
            err_cnt  <= err_d;
            fail_vec <= fail_d;
        end
    end

endmodule

// File: tb/tb_or_resp_checker.sv
// Bench for or_resp_checker: cycle-level reference model plus directed and random runs.
module tb_or_resp_checker;

    localparam int H       = 2;
    localparam int SLOT    = H + 1;
    localparam int RUN     = 4 * SLOT;
    localparam int ERR_MAX = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       x, y, z, busy, done, pass;
    logic [2:0] err_cnt;
    logic [3:0] fail_vec;

    logic [3:0] gate_tt = 4'b1110;
    logic       samp_mode = 1'b0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    // Reference model state: position within a run, expected outputs.
    logic       m_active = 1'b0;
    int         m_pos = 0;
    logic       m_x = 1'b0, m_y = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    logic [2:0] m_err = '0;
    logic [3:0] m_fail = '0;
    logic       in_check;

    or_resp_checker #(
        .HOLD_CYCLES(H),
        .ERR_W      (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
        .y       (y),
        .z       (z),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;

    // Gate under test: a truth table, or a gate that is only right during CHECK.
    assign in_check = m_active && ((m_pos % SLOT) == H);
    assign z = samp_mode ? (in_check ? (x | y) : ~(x | y)) : gate_tt[{x, y}];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        int         e;
        int         v;
        logic [3:0] f;
        if (!rst_n) begin
            m_active <= 1'b0; m_pos <= 0;
            m_x <= 1'b0; m_y <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_pass <= 1'b0; m_err <= '0; m_fail <= '0;
        end else if (m_active) begin
            e = int'(m_err);
            f = m_fail;
            v = m_pos / SLOT;
            if ((m_pos % SLOT) == H && z !== (m_x | m_y)) begin
                f[v] = 1'b1;
                if (e < ERR_MAX) e = e + 1;
            end
            m_err  <= 3'(e);
            m_fail <= f;
            if (m_pos == RUN - 1) begin
                m_active <= 1'b0;
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_x      <= 1'b0;
                m_y      <= 1'b0;
                m_pass   <= (e == 0);
            end else begin
                v = (m_pos + 1) / SLOT;
                m_pos <= m_pos + 1;
                m_x   <= v[1];
                m_y   <= v[0];
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_active <= 1'b1; m_pos <= 0;
            m_x <= 1'b0; m_y <= 1'b0; m_busy <= 1'b1;
            m_pass <= 1'b0; m_err <= '0; m_fail <= '0;
        end
    end

    // Every-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        chk("cmp_x", 32'(x), 32'(m_x));
        chk("cmp_y", 32'(y), 32'(m_y));
        chk("cmp_busy", 32'(busy), 32'(m_busy));
        chk("cmp_done", 32'(done), 32'(m_done));
        chk("cmp_pass", 32'(pass), 32'(m_pass));
        chk("cmp_err", 32'(err_cnt), 32'(m_err));
        chk("cmp_fail", 32'(fail_vec), 32'(m_fail));
        if (done) done_cnt++;
    end

    task automatic wait_done(output int bn, output logic [23:0] seq);
        bn  = 0;
        seq = '0;
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            if (busy) begin
                bn++;
                seq = {seq[21:0], x, y};
            end
            @(negedge clk);
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run(input string name, input logic [3:0] tt, input logic sm,
                       input int exp_err, input logic [3:0] exp_fail, input logic exp_pass);
        int         bn;
        logic [23:0] seq;
        gate_tt   = tt;
        samp_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bn, seq);
        chk({name, "_busy_len"}, 32'(bn), 32'd12);
        chk({name, "_xy_seq"}, 32'(seq), 32'(24'b000000_010101_101010_111111));
        chk({name, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({name, "_err"}, 32'(err_cnt), 32'(exp_err));
        chk({name, "_fail"}, 32'(fail_vec), 32'(exp_fail));
        @(negedge clk);
        chk({name, "_done_width"}, 32'(done), 32'd0);
        samp_mode = 1'b0;
    endtask

    initial begin
        int         d0;
        int         bn;
        logic [23:0] seq;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 32'({x, y, busy, done, pass, err_cnt, fail_vec}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("good", 4'b1110, 1'b0, 0, 4'b0000, 1'b1);
        run("stuck0", 4'b0000, 1'b0, 3, 4'b1110, 1'b0);
        run("and_gate", 4'b1000, 1'b0, 2, 4'b0110, 1'b0);
        run("sample_pt", 4'b1110, 1'b1, 0, 4'b0000, 1'b1);

        // Start pulse during APPLY of vector 2 is ignored.
        gate_tt = 4'b1110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

        // Start held high: next run accepted in the IDLE cycle after done.
        gate_tt = 4'b0000;
        start = 1'b1;
        wait_done(bn, seq);
        chk("b2b_first_err", 32'(err_cnt), 32'd3);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_err", 32'(err_cnt), 32'd3);
        @(negedge clk);
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        chk("b2b_cleared", 32'({pass, err_cnt, fail_vec}), 32'd0);
        start = 1'b0;
        gate_tt = 4'b1110;
        wait_done(bn, seq);
        chk("b2b_second_pass", 32'(pass), 32'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset during CHECK of vector 1.
        gate_tt = 4'b0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 32'({x, y, busy, done, pass, err_cnt, fail_vec}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        run("after_reset", 4'b1110, 1'b0, 0, 4'b0000, 1'b1);

        // Random start traffic and gate truth tables; checked by the model.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            if (i % 100 == 0) gate_tt = 4'($urandom);
            if (i == 437) begin
                #3 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
